m_stopwatch_ctrl: RTL
=====================

// Module: m_stopwatch_ctrl
// PURPOSE
//  Stopwatch controller for the 4-digit 7-segment board display, range 00.00-99.99 s.
//  Takes debounced switch levels from the debounce stage and runs a start/stop/lap/clear FSM.
//  Drives a prescaled 4-digit BCD count chain with ripple carries between digits.
//  Time-multiplexes the displayed digits onto one BCD bus for the external 7-seg decoder.
// PARAMETERS
//  TICK_DIV  500000  clk cycles per 10 ms count tick (>=2)
//  SCAN_DIV  50000   clk cycles each digit stays selected (>=1)
// PORTS
//  clk        in   1   system clock, all logic on rising edge
//  n_reset    in   1   asynchronous, active-low reset
//  sw_start   in   1   debounced start/stop switch level, active high
//  sw_lap     in   1   debounced lap switch level, active high
//  sw_clear   in   1   debounced clear switch level, active high
//  count_bcd  out  16  live count {s10,s1,h10,h1}, 4 BCD digits
//  digit_bcd  out  4   BCD value of the currently scanned digit
//  digit_sel  out  4   active-low one-hot digit enable
//  dp_n       out  1   active-low decimal point
//  running    out  1   1 in RUN or LAP
//  ovf        out  1   sticky flag, set on 99.99->00.00 wrap
// BEHAVIOUR
//  Reset (async on n_reset low), all registered:
//   state=IDLE; count=0; lap latch=0; prescaler=0; scan cnt=0; digit idx=0.
//   digit_sel=4'b1110; digit_bcd=0; dp_n=1; running=0; ovf=0.
//   Switch-history regs reset to 1, so a switch held through reset gives no edge.
//  Edges: rise_x = sw_x & ~sw_x_d, where sw_x_d is sw_x registered. The state changes on
//   the same clk edge that samples sw_x=1 while sw_x_d=0. Level holds give no repeat.
//  FSM (one event per cycle; priority clear > start > lap):
//   IDLE: start->RUN. Lap and clear have no effect.
//   RUN:  start->STOP; lap->LAP (latch count_bcd on that edge). Clear has no effect.
//   LAP:  start->STOP; lap->RUN. Clear has no effect.
//   STOP: clear->IDLE (count=0, ovf=0, latch=0); else start->RUN. Lap has no effect.
//  Prescaler: counts 0..TICK_DIV-1 only in RUN/LAP and is held at 0 in IDLE/STOP.
//   A tick is its wrap cycle. The first tick is TICK_DIV cycles after the clk edge that enters RUN.
//   The prescaler does not reset on RUN->LAP or LAP->RUN.
//  Count chain, on each tick:
//   h1 increments; 9->0 carries into h10; 9->0 carries into s1; 9->0 carries into s10.
//   99.99 -> 00.00 and sets ovf in the same cycle.
//   Digits never leave 0-9. count_bcd updates on the tick edge.
//  Display source: lap latch in LAP, count_bcd in all other states.
//   On LAP->RUN or LAP->STOP the display goes live on the next cycle.
//  Scan: counts 0..SCAN_DIV-1 in every state; digit idx 0..3 increments on wrap, 3->0.
//   idx0: h1, sel 1110.  idx1: h10, sel 1101.  idx2: s1, sel 1011.  idx3: s10, sel 0111.
//   dp_n=0 only at idx2. digit_bcd, digit_sel and dp_n are registered together,
//   so they never show a one-cycle mismatch.
//  Leading zeros are shown (no blanking).
//  Reset mid-count or mid-lap returns everything to the reset values immediately.
// TESTING (TICK_DIV=4, SCAN_DIV=2)
//  1. Reset with sw_start held 1, then keep it held -> state IDLE, count 0, running=0.
//  2. Pulse start, wait 40 clk -> running=1, count_bcd=16'h0010.
//     Pulse start again -> STOP, count frozen.
//  3. Preload path: run to 16'h9999, then one more tick -> count_bcd=16'h0000, ovf=1.
//     Pulse clear in STOP -> ovf=0, IDLE.
//  4. In RUN at 16'h0005, pulse lap -> scanned digits show 00.05 while count_bcd advances.
//     Pulse lap -> display is live again.
//  5. Start, lap and clear rising in the same cycle while in RUN -> STOP (start wins).
//     The lap latch is not updated.
//  6. Scan check: digit_sel follows 1110,1101,1011,0111 every 2 clk; dp_n=0 only with 1011.
//     In every cycle digit_bcd equals the selected digit.

Source files
------------

// File: rtl/m_stopwatch_ctrl.sv
// Stopwatch controller for a 4-digit 7-segment display, 00.00-99.99 s.
// Start/stop/lap/clear FSM driven by edges of debounced switch levels,
// a prescaled BCD count chain and a registered digit scanner.
// Handshake note: there is no valid/ready traffic here; the switches are
// plain levels, and an event is a rising edge seen on a single clock edge.
module m_stopwatch_ctrl #(
  parameter int TICK_DIV = 500000,
  parameter int SCAN_DIV = 50000
) (
  input  logic        clk,
  input  logic        n_reset,
  input  logic        sw_start,
  input  logic        sw_lap,
  input  logic        sw_clear,
  output logic [15:0] count_bcd,
  output logic [3:0]  digit_bcd,
  output logic [3:0]  digit_sel,
  output logic        dp_n,
  output logic        running,
  output logic        ovf
);

  localparam int PW = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
  localparam int SW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_LAP, S_STOP} state_t;

  state_t        state, state_n;
  logic          start_d, lap_d, clear_d;
  logic          rise_start, rise_lap, rise_clear;
  logic          run_active, run_next, do_clear, do_latch, tick;
  logic [PW-1:0] presc;
  logic [SW-1:0] scan_cnt;
  logic [1:0]    idx, idx_n;
  logic          scan_wrap;
  logic [3:0]    h1, h10, s1, s10;
  logic [15:0]   lap_latch, disp;

  assign rise_start = sw_start & ~start_d;
  assign rise_lap   = sw_lap   & ~lap_d;
  assign rise_clear = sw_clear & ~clear_d;
  assign count_bcd  = {s10, s1, h10, h1};

  // Switch history; reset high so a switch held through reset is not an edge
  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) begin
      start_d <= 1'b1;
      lap_d   <= 1'b1;
      clear_d <= 1'b1;
    end else begin
      start_d <= sw_start;
      lap_d   <= sw_lap;
      clear_d <= sw_clear;
    end
  end

  // FSM state register
  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) state <= S_IDLE;
    else          state <= state_n;
  end

  // FSM next state; one event per cycle, clear > start > lap
  always_comb begin
    state_n = state;
    case (state)
      S_IDLE: if (rise_start) state_n = S_RUN;
      S_RUN:  if (rise_start) state_n = S_STOP;
              else if (rise_lap) state_n = S_LAP;
      S_LAP:  if (rise_start) state_n = S_STOP;
              else if (rise_lap) state_n = S_RUN;
      S_STOP: if (rise_clear) state_n = S_IDLE;
              else if (rise_start) state_n = S_RUN;
      default: state_n = S_IDLE;
    endcase
  end

  // FSM outputs: qualifiers for the datapath
  always_comb begin
    run_active = (state == S_RUN) || (state == S_LAP);
    run_next   = (state_n == S_RUN) || (state_n == S_LAP);
    do_clear   = (state == S_STOP) && rise_clear;
    do_latch   = (state == S_RUN) && !rise_start && rise_lap;
    tick       = run_active && (presc == PW'(TICK_DIV - 1));
  end

  // Prescaler: free-runs while counting, parked at 0 otherwise
  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset)                presc <= '0;
    else if (run_active && run_next)
      presc <= tick ? '0 : presc + PW'(1);
    else                         presc <= '0;
  end

  // BCD count chain with ripple carries, sticky overflow and lap latch
  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) begin
      {s10, s1, h10, h1} <= 16'h0000;
      ovf                <= 1'b0;
      lap_latch          <= 16'h0000;
    end else if (do_clear) begin
      {s10, s1, h10, h1} <= 16'h0000;
      ovf                <= 1'b0;
      lap_latch          <= 16'h0000;
    end else begin
      if (do_latch) lap_latch <= count_bcd;
      if (tick) begin
        if (count_bcd == 16'h9999) ovf <= 1'b1;
        if (h1 == 4'd9) begin
          h1 <= 4'd0;
          if (h10 == 4'd9) begin
            h10 <= 4'd0;
            if (s1 == 4'd9) begin
              s1  <= 4'd0;
              s10 <= (s10 == 4'd9) ? 4'd0 : s10 + 4'd1;
            end else s1 <= s1 + 4'd1;
          end else h10 <= h10 + 4'd1;
        end else h1 <= h1 + 4'd1;
      end
    end
  end

  // Running flag registered from the next state so it tracks the state exactly
  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) running <= 1'b0;
    else          running <= run_next;
  end

  assign scan_wrap = (scan_cnt == SW'(SCAN_DIV - 1));
  assign idx_n     = scan_wrap ? idx + 2'd1 : idx;
  assign disp      = (state == S_LAP) ? lap_latch : count_bcd;

  // Digit scanner; value, select and decimal point registered together
  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) begin
      scan_cnt  <= '0;
      idx       <= 2'd0;
      digit_bcd <= 4'd0;
      digit_sel <= 4'b1110;
      dp_n      <= 1'b1;
    end else begin
      scan_cnt  <= scan_wrap ? '0 : scan_cnt + SW'(1);
      idx       <= idx_n;
      digit_sel <= ~(4'b0001 << idx_n);
      dp_n      <= (idx_n != 2'd2);
      case (idx_n)
        2'd0:    digit_bcd <= disp[3:0];
        2'd1:    digit_bcd <= disp[7:4];
        2'd2:    digit_bcd <= disp[11:8];
        default: digit_bcd <= disp[15:12];
      endcase
    end
  end

endmodule
